// File: rtl/tmr_vote_monitor.sv
// N-channel bitwise majority voter with parity, one-deep valid/ready output stage,
// and per-channel disagreement tracking (saturating error counters, sticky faults).
//
//  state      | meaning
//  -----------+------------------------------------------------------
//  ST_OK      | channel agreed with the vote on its last counted sample
//  ST_SUSPECT | 1..THRESH-1 consecutive mismatching samples
//  ST_FAULT   | THRESH consecutive mismatches seen; sticky until clr_fault/reset
module tmr_vote_monitor #(
  parameter int CH     = 3,
  parameter int WIDTH  = 8,
  parameter int THRESH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*WIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_vote,
  output logic [WIDTH-1:0]      out_parity,
  output logic [CH-1:0]         out_mismatch,
  output logic                  out_unanimous,
  output logic [CH-1:0]         fault,
  output logic [CH*CNT_W-1:0]   err_cnt,
  input  logic                  clr_fault
);

  localparam int CW = $clog2(THRESH + 1);
  localparam int VW = $clog2(CH + 1);
  localparam logic [CW-1:0] THR = CW'(THRESH);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAULT} state_t;

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_vote;
  logic [WIDTH-1:0]     r_parity;
  logic [CH-1:0]        r_mismatch;
  logic                 r_unanimous;
  state_t               r_state  [CH];
  logic [CW-1:0]        r_consec [CH];
  logic [CNT_W-1:0]     r_err    [CH];

  logic                 w_acc_in;
  logic [WIDTH-1:0]     w_vote;
  logic [WIDTH-1:0]     w_parity;
  logic [CH-1:0]        w_mismatch;
  logic                 w_unanimous;
  state_t               w_state_nxt  [CH];
  logic [CW-1:0]        w_consec_nxt [CH];

  assign in_ready = !r_out_valid || out_ready;
  assign w_acc_in = in_valid && in_ready;

  always_comb begin : p_vote
    logic [VW-1:0] ones;
    w_vote   = '0;
    w_parity = '0;
    ones     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = '0;
      for (int k = 0; k < CH; k++) begin
        ones        = ones + VW'(in_data[k*WIDTH+i]);
        w_parity[i] = w_parity[i] ^ in_data[k*WIDTH+i];
      end
      w_vote[i] = (ones > VW'(CH/2));
    end
  end

  always_comb begin
    w_mismatch  = '0;
    w_unanimous = 1'b1;
    for (int k = 0; k < CH; k++) begin
      w_mismatch[k] = (in_data[k*WIDTH +: WIDTH] != w_vote);
      if (in_data[k*WIDTH +: WIDTH] != in_data[0 +: WIDTH]) w_unanimous = 1'b0;
    end
  end

  // clr_fault is applied before the sample accepted in the same cycle is counted.
  always_comb begin : p_chan
    logic [CW-1:0] base_c;
    logic          base_f;
    logic          nxt_f;
    base_c = '0;
    base_f = 1'b0;
    nxt_f  = 1'b0;
    for (int k = 0; k < CH; k++) begin
      base_c          = clr_fault ? '0 : r_consec[k];
      base_f          = !clr_fault && (r_state[k] == ST_FAULT);
      w_consec_nxt[k] = base_c;
      nxt_f           = base_f;
      if (w_acc_in) begin
        if (w_mismatch[k]) begin
          w_consec_nxt[k] = (base_c >= THR) ? THR : base_c + CW'(1);
          if (w_consec_nxt[k] == THR) nxt_f = 1'b1;
        end else begin
          w_consec_nxt[k] = '0;
        end
      end
      if (nxt_f)                      w_state_nxt[k] = ST_FAULT;
      else if (w_consec_nxt[k] == '0) w_state_nxt[k] = ST_OK;
      else                            w_state_nxt[k] = ST_SUSPECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) begin
        r_state[k]  <= ST_OK;
        r_consec[k] <= '0;
        r_err[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        r_state[k]  <= w_state_nxt[k];
        r_consec[k] <= w_consec_nxt[k];
        if (w_acc_in && w_mismatch[k] && (r_err[k] != {CNT_W{1'b1}}))
          r_err[k] <= r_err[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_vote      <= '0;
      r_parity    <= '0;
      r_mismatch  <= '0;
      r_unanimous <= 1'b0;
    end else if (w_acc_in) begin
      r_out_valid <= 1'b1;
      r_vote      <= w_vote;
      r_parity    <= w_parity;
      r_mismatch  <= w_mismatch;
      r_unanimous <= w_unanimous;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_vote      = r_vote;
  assign out_parity    = r_parity;
  assign out_mismatch  = r_mismatch;
  assign out_unanimous = r_unanimous;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    assign fault[g]                   = (r_state[g] == ST_FAULT);
    assign err_cnt[g*CNT_W +: CNT_W]  = r_err[g];
  end

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor: vector table plus hand-written sequences
// for faults, clear, backpressure, counter saturation and asynchronous reset.
module tb_tmr_vote_monitor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [23:0] in_data;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [7:0]  out_vote, out_vote2;
  logic [7:0]  out_parity, out_parity2;
  logic [2:0]  out_mismatch, out_mismatch2;
  logic        out_unanimous, out_unanimous2;
  logic [2:0]  fault, fault2;
  logic [23:0] err_cnt;
  logic [5:0]  err_cnt2;
  logic        clr_fault;

  int checks   = 0;
  int failures = 0;

  tmr_vote_monitor #(.CH(3), .WIDTH(8), .THRESH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_vote(out_vote), .out_parity(out_parity), .out_mismatch(out_mismatch),
    .out_unanimous(out_unanimous), .fault(fault), .err_cnt(err_cnt),
    .clr_fault(clr_fault)
  );

  tmr_vote_monitor #(.CH(3), .WIDTH(8), .THRESH(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_vote(out_vote2), .out_parity(out_parity2), .out_mismatch(out_mismatch2),
    .out_unanimous(out_unanimous2), .fault(fault2), .err_cnt(err_cnt2),
    .clr_fault(clr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic [7:0]  vote;
    logic [7:0]  par;
    logic [2:0]  mm;
    logic        un;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clr_fault = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [23:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    // {ch2, ch1, ch0}
    vecs[0] = '{24'hAACCF0, 8'hE8, 8'h96, 3'b111, 1'b0};
    vecs[1] = '{24'h5A5A5A, 8'h5A, 8'h5A, 3'b000, 1'b1};
    vecs[2] = '{24'h5A5A5A, 8'h5A, 8'h5A, 3'b000, 1'b1};
    vecs[3] = '{24'h5A5A5A, 8'h5A, 8'h5A, 3'b000, 1'b1};
    vecs[4] = '{24'hFF0F0F, 8'h0F, 8'hFF, 3'b100, 1'b0};
    vecs[5] = '{24'h030100, 8'h01, 8'h02, 3'b101, 1'b0};
    vecs[6] = '{24'hFFFFFF, 8'hFF, 8'hFF, 3'b000, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clr_fault = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_vote", out_vote, 0);
    chk("rst_parity", out_parity, 0);
    chk("rst_mismatch", out_mismatch, 0);
    chk("rst_unanimous", out_unanimous, 0);
    chk("rst_fault", fault, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      in_data  = vecs[i].data;
      in_valid = 1'b1;
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_vote", i), out_vote, vecs[i].vote);
      chk($sformatf("vec%0d_parity", i), out_parity, vecs[i].par);
      chk($sformatf("vec%0d_mismatch", i), out_mismatch, vecs[i].mm);
      chk($sformatf("vec%0d_unanimous", i), out_unanimous, vecs[i].un);
    end
    in_valid = 1'b0;
    step();
    chk("table_drain_valid", out_valid, 0);
    chk("table_err_cnt", err_cnt, 24'h030102);
    chk("table_fault", fault, 0);

    // channel 1 corrupted: fault on the 4th consecutive accept
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      send(24'h00FF00);
      chk($sformatf("corrupt%0d_fault", n), fault, (n == 4) ? 3'b010 : 3'b000);
      chk($sformatf("corrupt%0d_mismatch", n), out_mismatch, 3'b010);
    end
    chk("corrupt_err1", err_cnt[15:8], 8'd4);
    chk("corrupt_err0", err_cnt[7:0], 8'd0);
    send(24'h5A5A5A);
    chk("good_after_fault", fault, 3'b010);
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    chk("clr_fault", fault, 3'b000);
    chk("clr_keeps_err", err_cnt[15:8], 8'd4);

    // clear must zero the run length, then count the coincident sample as 1
    send(24'h00FF00);
    send(24'h00FF00);
    in_data   = 24'h00FF00;
    in_valid  = 1'b1;
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    in_valid  = 1'b0;
    chk("clr_same_cycle_fault", fault, 3'b000);
    send(24'h00FF00);
    chk("after_clr_2_fault", fault, 3'b000);
    send(24'h00FF00);
    chk("after_clr_3_fault", fault, 3'b000);
    send(24'h00FF00);
    chk("after_clr_4_fault", fault, 3'b010);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    in_data   = 24'hAACCF0;
    in_valid  = 1'b1;
    step();
    chk("bp_valid", out_valid, 1);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_vote_a", out_vote, 8'hE8);
    in_data = 24'h5A5A5A;
    step();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_vote", out_vote, 8'hE8);
    chk("bp_hold_unanimous", out_unanimous, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", in_ready, 1);
    @(negedge clk);
    step();
    in_valid = 1'b0;
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_vote", out_vote, 8'h5A);
    chk("bp_b_unanimous", out_unanimous, 1);
    step();
    chk("bp_drain", out_valid, 0);

    // CNT_W=2 saturation on channel 0
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      send(24'h0000FF);
      chk($sformatf("sat%0d_err0_w2", n), err_cnt2[1:0], (n > 3) ? 2'd3 : 2'(n));
    end
    chk("sat_err0_w8", err_cnt[7:0], 8'd5);
    chk("sat_fault_w2", fault2, 3'b001);

    // asynchronous reset with a held result and a fault set
    do_reset();
    for (int n = 0; n < 4; n++) send(24'h00FF00);
    out_ready = 1'b0;
    step();
    chk("pre_arst_valid", out_valid, 1);
    chk("pre_arst_fault", fault, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_fault", fault, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_mismatch", out_mismatch, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk("arst_in_ready", in_ready, 1);
    send(24'hAACCF0);
    chk("post_arst_valid", out_valid, 1);
    chk("post_arst_vote", out_vote, 8'hE8);
    chk("post_arst_parity", out_parity, 8'h96);
    chk("post_arst_err", err_cnt, 24'h010101);
    chk("post_arst_fault", fault, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
